bbox_crop_reader: RTL and testbench



---
 rtl/bbox_crop_reader.sv | 180 ++++++++++++++++++
 tb/tb_bbox_crop_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bbox_crop_reader.sv
// bbox_crop_reader: walks frame RAM inside a bounding box in raster order and
// streams the cropped pixels out on a valid/ready interface with sof/eol/eof markers.
module bbox_crop_reader #(
    parameter int IMG_W   = 200,
    parameter int IMG_H   = 150,
    parameter int ADDR_W  = 32,
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [COORD_W-1:0] x_min_i,
    input  logic [COORD_W-1:0] x_max_i,
    input  logic [COORD_W-1:0] y_min_i,
    input  logic [COORD_W-1:0] y_max_i,
    output logic [ADDR_W-1:0]  addr_o,
    input  logic [7:0]         rddata_i,
    output logic [7:0]         out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               out_sof_o,
    output logic               out_eol_o,
    output logic               out_eof_o,
    output logic [COORD_W-1:0] crop_w_o,
    output logic [COORD_W-1:0] crop_h_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
    localparam logic [COORD_W-1:0] W_C   = COORD_W'(IMG_W);
    localparam logic [COORD_W-1:0] H_C   = COORD_W'(IMG_H);
    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);
    localparam logic [ADDR_W-1:0]  W_A   = ADDR_W'(IMG_W);

    logic [2:0]         state_q, state_d;
    logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
    logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] crop_w_q, crop_w_d, crop_h_q, crop_h_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d, addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

    always_comb begin
        state_d    = state_q;
        x_min_d    = x_min_q;
        x_max_d    = x_max_q;
        y_min_d    = y_min_q;
        y_max_d    = y_max_q;
        x_d        = x_q;
        y_d        = y_q;
        crop_w_d   = crop_w_q;
        crop_h_d   = crop_h_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        eof_d      = eof_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                x_min_d = x_min_i;
                x_max_d = x_max_i;
                y_min_d = y_min_i;
                y_max_d = y_max_i;
                busy_d  = 1'b1;
                err_d   = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: if (x_min_q <= x_max_q && y_min_q <= y_max_q && x_max_q < W_C && y_max_q < H_C) begin
                crop_w_d   = x_max_q - x_min_q + ONE_C;
                crop_h_d   = y_max_q - y_min_q + ONE_C;
                x_d        = x_min_q;
                y_d        = y_min_q;
                row_base_d = ADDR_W'(y_min_q) * W_A;
                state_d    = S_ISSUE;
            end else begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_FINISH;
            end
            S_ISSUE: begin
                addr_d  = row_base_q + ADDR_W'(x_q);
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d  = rddata_i;
                sof_d   = x_q == x_min_q && y_q == y_min_q;
                eol_d   = x_q == x_max_q;
                eof_d   = x_q == x_max_q && y_q == y_max_q;
                valid_d = 1'b1;
                state_d = S_PRESENT;
            end
            S_PRESENT: if (out_ready_i) begin
                valid_d = 1'b0;
                // row advance is incremental so no multiplier sits in the pixel loop
                if (x_q < x_max_q) x_d = x_q + ONE_C;
                else begin
                    x_d        = x_min_q;
                    y_d        = y_q + ONE_C;
                    row_base_d = row_base_q + W_A;
                end
                done_d  = eof_q;
                state_d = eof_q ? S_FINISH : S_ISSUE;
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            x_min_q    <= '0;
            x_max_q    <= '0;
            y_min_q    <= '0;
            y_max_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            crop_w_q   <= '0;
            crop_h_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_min_q    <= x_min_d;
            x_max_q    <= x_max_d;
            y_min_q    <= y_min_d;
            y_max_q    <= y_max_d;
            x_q        <= x_d;
            y_q        <= y_d;
            crop_w_q   <= crop_w_d;
            crop_h_q   <= crop_h_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign addr_o      = addr_q;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_sof_o   = sof_q;
    assign out_eol_o   = eol_q;
    assign out_eof_o   = eof_q;
    assign crop_w_o    = crop_w_q;
    assign crop_h_o    = crop_h_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_bbox_crop_reader.sv
// tb_bbox_crop_reader: scoreboard bench for bbox_crop_reader against a
// combinational frame-RAM model.
module tb_bbox_crop_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [10:0] x_min_i = '0, x_max_i = '0, y_min_i = '0, y_max_i = '0;
    logic [31:0] addr_o;
    logic [7:0]  rddata_i, out_data_o;
    logic        out_valid_o, out_ready_i = 1'b1;
    logic        out_sof_o, out_eol_o, out_eof_o;
    logic [10:0] crop_w_o, crop_h_o;
    logic        busy_o, done_o, err_o;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
        logic        s, l, e;
    } beat_t;

    beat_t       q[$];
    beat_t       snap;
    int          n_chk = 0, n_pass = 0, hs_cnt = 0;
    bit          stalled = 0, pend_done = 0, rdy_mode = 0;
    logic [3:0]  pat = 4'b1001;

    bbox_crop_reader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .x_min_i(x_min_i), .x_max_i(x_max_i), .y_min_i(y_min_i), .y_max_i(y_max_i),
        .addr_o(addr_o), .rddata_i(rddata_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sof_o(out_sof_o), .out_eol_o(out_eol_o), .out_eof_o(out_eof_o),
        .crop_w_o(crop_w_o), .crop_h_o(crop_h_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    assign rddata_i = pix(addr_o);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ready pattern 1,0,0,1 (LSB first) when rdy_mode is set
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            out_ready_i = rdy_mode ? pat[k % 4] : 1'b1;
            k++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled   = 0;
            pend_done = 0;
        end else begin
            if (pend_done) chk("done_after_eof", {63'd0, done_o}, 64'd1);
            if (stalled) begin
                chk("stall_valid", {63'd0, out_valid_o}, 64'd1);
                chk("stall_hold", {21'd0, addr_o, out_data_o, out_sof_o, out_eol_o, out_eof_o}, {21'd0, snap});
            end
            stalled = out_valid_o && !out_ready_i;
            snap    = {addr_o, out_data_o, out_sof_o, out_eol_o, out_eof_o};
            pend_done = out_valid_o && out_ready_i && out_eof_o;
            if (out_valid_o && out_ready_i) begin
                hs_cnt++;
                if (q.size() == 0) chk("unexpected_beat", {63'd0, out_valid_o}, 64'd0);
                else chk("beat", {21'd0, addr_o, out_data_o, out_sof_o, out_eol_o, out_eof_o}, {21'd0, q.pop_front()});
            end
        end
    end

    task automatic push_box(input int x0, input int x1, input int y0, input int y1);
        beat_t b;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                b.a = 32'(y * 200 + x);
                b.d = pix(b.a);
                b.s = (x == x0 && y == y0);
                b.l = (x == x1);
                b.e = (x == x1 && y == y1);
                q.push_back(b);
            end
    endtask

    task automatic start_job(input int x0, input int x1, input int y0, input int y1);
        @(posedge clk);
        #1;
        x_min_i = 11'(x0);
        x_max_i = 11'(x1);
        y_min_i = 11'(y0);
        y_max_i = 11'(y1);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < 1000);
        chk("done_seen", {63'd0, done_o}, 64'd1);
    endtask

    task automatic job(input int x0, input int x1, input int y0, input int y1, input int exp_n, input bit idle_chk);
        bit ok;
        int n;
        ok = x0 <= x1 && y0 <= y1 && x1 < 200 && y1 < 150;
        if (ok) push_box(x0, x1, y0, y1);
        start_job(x0, x1, y0, y1);
        wait_done(n);
        if (exp_n != 0) chk("latency", 64'(n), 64'(exp_n));
        chk("err", {63'd0, err_o}, {63'd0, !ok});
        chk("busy_in_finish", {63'd0, busy_o}, 64'd1);
        if (ok) begin
            chk("crop_w", {53'd0, crop_w_o}, 64'(x1 - x0 + 1));
            chk("crop_h", {53'd0, crop_h_o}, 64'(y1 - y0 + 1));
        end
        chk("drained", 64'(q.size()), 64'd0);
        if (idle_chk) begin
            @(negedge clk);
            chk("busy_off", {63'd0, busy_o}, 64'd0);
            chk("done_pulse", {63'd0, done_o}, 64'd0);
            chk("err_sticky", {63'd0, err_o}, {63'd0, !ok});
        end
    endtask

    initial begin
        int n, base;
        repeat (2) @(negedge clk);
        chk("reset_outs", {17'd0, addr_o, out_data_o, out_valid_o, out_sof_o, out_eol_o, out_eof_o, busy_o, done_o, err_o}, 64'd0);
        chk("reset_crop", {42'd0, crop_w_o, crop_h_o}, 64'd0);
        rst_n = 1'b1;
        job(10, 12, 5, 6, 20, 1);
        rdy_mode = 1;
        job(10, 12, 5, 6, 0, 1);
        rdy_mode = 0;
        job(0, 0, 0, 0, 5, 1);
        job(199, 199, 149, 149, 5, 1);
        job(20, 10, 0, 0, 2, 1);
        job(0, 0, 0, 150, 2, 1);
        job(0, 1, 0, 0, 0, 1);
        // reset while beat 3 is presented
        base = hs_cnt;
        push_box(10, 12, 5, 6);
        start_job(10, 12, 5, 6);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(hs_cnt == base + 2 && out_valid_o) && n < 200);
        chk("reached_beat3", {63'd0, out_valid_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midjob_reset_outs", {17'd0, addr_o, out_data_o, out_valid_o, out_sof_o, out_eol_o, out_eof_o, busy_o, done_o, err_o}, 64'd0);
        chk("midjob_reset_crop", {42'd0, crop_w_o, crop_h_o}, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        job(3, 4, 7, 7, 8, 1);
        // start pulse while busy must be ignored
        push_box(5, 6, 2, 3);
        start_job(5, 6, 2, 3);
        repeat (4) @(posedge clk);
        #1;
        x_min_i = 11'd0;
        x_max_i = 11'd0;
        y_min_i = 11'd0;
        y_max_i = 11'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(n);
        chk("ignored_crop", {42'd0, crop_w_o, crop_h_o}, {42'd0, 11'd2, 11'd2});
        chk("ignored_drained", 64'(q.size()), 64'd0);
        // back-to-back: second start issued in the cycle after done
        job(1, 2, 1, 1, 0, 0);
        job(7, 7, 8, 9, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
